// File: rtl/display_hdmi_vga_timing_det.sv
// Receive-side video timing detector.
// Recovers active-pixel coordinates from a raw HS/VS/DE stream, measures line
// and frame geometry, and reports lock once consecutive frames agree.
module display_hdmi_vga_timing_det #(
  parameter int PW          = 14,
  parameter int VW          = 12,
  parameter int LOCK_FRAMES = 3,
  parameter int SYNC_POL    = 0
) (
  input  logic          in_pclk,
  input  logic          in_rst,
  input  logic          in_hs,
  input  logic          in_vs,
  input  logic          in_de,
  output logic [PW-1:0] out_x,
  output logic [VW-1:0] out_y,
  output logic          out_de,
  output logic          out_sof,
  output logic          out_eol,
  output logic [PW-1:0] out_h_total,
  output logic [PW-1:0] out_h_active,
  output logic [VW-1:0] out_v_total,
  output logic [VW-1:0] out_v_active,
  output logic          out_locked,
  output logic          out_err
);

  localparam logic          POL    = (SYNC_POL != 0);
  localparam logic [PW-1:0] HMAX   = '1;
  localparam logic [2:0]    LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_TRACK   = 2'd2
  } state_t;

  // Saturating increment for horizontal-width counters.
  function automatic logic [PW-1:0] sat_inc_h(input logic [PW-1:0] v);
    return (v == HMAX) ? v : v + 1'b1;
  endfunction

  // Saturating increment for the lock match counter.
  function automatic logic [2:0] sat_inc_m(input logic [2:0] v);
    return (v == LOCK_N) ? v : v + 1'b1;
  endfunction

  // Input registers: _p0 is the first capture, _p1 the edge-reference copy.
  logic hs_p0_q, vs_p0_q, de_p0_q;
  logic hs_p1_q, vs_p1_q, de_p1_q;

  // Coordinate path state and outputs.
  logic [PW-1:0] x_cnt_q;
  logic [VW-1:0] y_cnt_q;
  logic          de_p2_q, sof_p2_q, eol_p2_q;
  logic [PW-1:0] x_p2_q;
  logic [VW-1:0] y_p2_q;

  // Measurement state.
  logic [PW-1:0] h_cnt_q, h_len_q, dw_cnt_q, ref_w_q;
  logic          have_ref_q, incons_q;
  logic [VW-1:0] line_cnt_q, act_cnt_q;

  // Published values and FSM.
  state_t        state_q;
  logic [2:0]    match_q;
  logic [PW-1:0] h_tot_q, h_act_q;
  logic [VW-1:0] v_tot_q, v_act_q;
  logic          locked_q, err_q;

  // Edge events, all referenced to the _p0 sample.
  logic hs_start, vs_start, de_fall;
  assign hs_start = (hs_p0_q == POL) && (hs_p1_q != POL);
  assign vs_start = (vs_p0_q == POL) && (vs_p1_q != POL);
  assign de_fall  = de_p1_q && !de_p0_q;

  // Frame results as they stand including this cycle's events, so a line or
  // DE edge coincident with VS start is credited to the ending frame.
  logic [PW-1:0] h_len_d, h_act_d;
  logic [VW-1:0] v_tot_d, v_act_d;
  logic          w_mis, incons_d, h_sat_hit, same_geom;

  assign h_len_d   = hs_start ? sat_inc_h(h_cnt_q) : h_len_q;
  assign h_act_d   = have_ref_q ? ref_w_q : (de_fall ? dw_cnt_q : '0);
  assign v_tot_d   = line_cnt_q + {{(VW-1){1'b0}}, hs_start};
  assign v_act_d   = act_cnt_q + {{(VW-1){1'b0}}, de_fall};
  assign w_mis     = de_fall && have_ref_q && (dw_cnt_q != ref_w_q);
  assign incons_d  = incons_q || w_mis;
  assign h_sat_hit = !hs_start && (h_cnt_q == HMAX - 1'b1);
  assign same_geom = (h_len_d == h_tot_q) && (h_act_d == h_act_q) &&
                     (v_tot_d == v_tot_q) && (v_act_d == v_act_q) && !incons_d;

  // ---- stage p0/p1: input capture and edge reference ----
  // Register the raw syncs twice so edges are seen between the two copies.
  always_ff @(posedge in_pclk or posedge in_rst) begin
    if (in_rst) begin
      hs_p0_q <= 1'b0;
      vs_p0_q <= 1'b0;
      de_p0_q <= 1'b0;
      hs_p1_q <= 1'b0;
      vs_p1_q <= 1'b0;
      de_p1_q <= 1'b0;
    end else begin
      hs_p0_q <= in_hs;
      vs_p0_q <= in_vs;
      de_p0_q <= in_de;
      hs_p1_q <= hs_p0_q;
      vs_p1_q <= vs_p0_q;
      de_p1_q <= de_p0_q;
    end
  end

  // ---- stage p2: coordinate outputs ----
  // Pixel at _p1 is emitted with _p0 as one-cycle lookahead for end-of-line.
  always_ff @(posedge in_pclk or posedge in_rst) begin
    if (in_rst) begin
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      de_p2_q  <= 1'b0;
      sof_p2_q <= 1'b0;
      eol_p2_q <= 1'b0;
      x_p2_q   <= '0;
      y_p2_q   <= '0;
    end else begin
      x_cnt_q  <= de_p1_q ? x_cnt_q + 1'b1 : '0;
      if (vs_start) begin
        y_cnt_q <= '0;
      end else if (de_fall) begin
        y_cnt_q <= y_cnt_q + 1'b1;
      end
      de_p2_q  <= de_p1_q;
      sof_p2_q <= de_p1_q && (x_cnt_q == '0) && (y_cnt_q == '0);
      eol_p2_q <= de_fall;
      x_p2_q   <= de_p1_q ? x_cnt_q : '0;
      y_p2_q   <= de_p1_q ? y_cnt_q : '0;
    end
  end

  // Line-level measurement: line period, DE width and per-frame reference.
  always_ff @(posedge in_pclk or posedge in_rst) begin
    if (in_rst) begin
      h_cnt_q    <= '0;
      h_len_q    <= '0;
      dw_cnt_q   <= '0;
      ref_w_q    <= '0;
      have_ref_q <= 1'b0;
      incons_q   <= 1'b0;
      line_cnt_q <= '0;
      act_cnt_q  <= '0;
    end else begin
      h_cnt_q  <= hs_start ? '0 : sat_inc_h(h_cnt_q);
      h_len_q  <= h_len_d;
      dw_cnt_q <= de_p0_q ? sat_inc_h(dw_cnt_q) : '0;
      if (vs_start) begin
        line_cnt_q <= '0;
        act_cnt_q  <= '0;
        ref_w_q    <= '0;
        have_ref_q <= 1'b0;
        incons_q   <= 1'b0;
      end else begin
        line_cnt_q <= v_tot_d;
        act_cnt_q  <= v_act_d;
        incons_q   <= incons_d;
        if (de_fall && !have_ref_q) begin
          ref_w_q    <= dw_cnt_q;
          have_ref_q <= 1'b1;
        end
      end
    end
  end

  // Lock FSM: publish geometry at frame boundaries and track stability.
  always_ff @(posedge in_pclk or posedge in_rst) begin
    if (in_rst) begin
      state_q  <= S_SEARCH;
      match_q  <= '0;
      h_tot_q  <= '0;
      h_act_q  <= '0;
      v_tot_q  <= '0;
      v_act_q  <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= h_sat_hit || w_mis;
      if (vs_start) begin
        case (state_q)
          S_SEARCH: begin
            state_q <= S_MEASURE;
          end
          S_MEASURE: begin
            h_tot_q  <= h_len_d;
            h_act_q  <= h_act_d;
            v_tot_q  <= v_tot_d;
            v_act_q  <= v_act_d;
            match_q  <= '0;
            locked_q <= 1'b0;
            state_q  <= S_TRACK;
          end
          S_TRACK: begin
            if (same_geom) begin
              match_q  <= sat_inc_m(match_q);
              locked_q <= (sat_inc_m(match_q) == LOCK_N);
            end else begin
              h_tot_q  <= h_len_d;
              h_act_q  <= h_act_d;
              v_tot_q  <= v_tot_d;
              v_act_q  <= v_act_d;
              match_q  <= '0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          default: begin
            state_q <= S_SEARCH;
          end
        endcase
      end
    end
  end

  assign out_x        = x_p2_q;
  assign out_y        = y_p2_q;
  assign out_de       = de_p2_q;
  assign out_sof      = sof_p2_q;
  assign out_eol      = eol_p2_q;
  assign out_h_total  = h_tot_q;
  assign out_h_active = h_act_q;
  assign out_v_total  = v_tot_q;
  assign out_v_active = v_act_q;
  assign out_locked   = locked_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_display_hdmi_vga_timing_det.sv
// Self-checking bench for display_hdmi_vga_timing_det.
// A frame generator drives HS/VS/DE and pushes the expected coordinate word for
// every cycle into a queue; the word is popped when the DUT emits that pixel.
module tb_display_hdmi_vga_timing_det;
  localparam int   PW          = 14;
  localparam int   VW          = 12;
  localparam int   LOCK_FRAMES = 3;
  localparam int   SYNC_POL    = 0;
  localparam logic POL         = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hs  = 1'b1;
  logic          vs  = 1'b1;
  logic          de  = 1'b0;
  logic [PW-1:0] out_x, out_h_total, out_h_active;
  logic [VW-1:0] out_y, out_v_total, out_v_active;
  logic          out_de, out_sof, out_eol, out_locked, out_err;

  always #5 clk = ~clk;

  display_hdmi_vga_timing_det #(
    .PW(PW), .VW(VW), .LOCK_FRAMES(LOCK_FRAMES), .SYNC_POL(SYNC_POL)
  ) dut (
    .in_pclk(clk), .in_rst(rst), .in_hs(hs), .in_vs(vs), .in_de(de),
    .out_x(out_x), .out_y(out_y), .out_de(out_de), .out_sof(out_sof),
    .out_eol(out_eol), .out_h_total(out_h_total), .out_h_active(out_h_active),
    .out_v_total(out_v_total), .out_v_active(out_v_active),
    .out_locked(out_locked), .out_err(out_err)
  );

  typedef struct packed {
    logic          de;
    logic          sof;
    logic          eol;
    logic [PW-1:0] x;
    logic [VW-1:0] y;
  } pix_t;

  pix_t exp_q[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   err_cnt = 0;

  // Count out_err pulses; each pulse is one cycle wide.
  always @(negedge clk) begin
    if (out_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One pixel clock: compare the pixel driven three steps ago, then drive.
  task automatic step(input logic h, input logic v, input logic d, input pix_t e);
    pix_t o;
    @(negedge clk);
    if (exp_q.size() == 3) begin
      o = exp_q.pop_front();
      chk_eq("pix", {out_de, out_sof, out_eol, out_x, out_y}, o);
    end
    hs = h;
    vs = v;
    de = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(~POL, ~POL, 1'b0, '0);
  endtask

  task automatic gen_frame(input int hsw, input int hbp, input int hact, input int hfp,
                           input int vsw, input int vbp, input int vact, input int vfp,
                           input int bad_line, input int stop_at);
    int   n, htot, vtot, a, p, w;
    logic h, v, d;
    pix_t e;
    n    = 0;
    htot = hsw + hbp + hact + hfp;
    vtot = vsw + vbp + vact + vfp;
    for (int l = 0; l < vtot; l++) begin
      a = l - (vsw + vbp);
      w = (a == bad_line) ? hact - 1 : hact;
      for (int c = 0; c < htot; c++) begin
        if (stop_at >= 0 && n == stop_at) return;
        p = c - (hsw + hbp);
        h = (c < hsw) ? POL : ~POL;
        v = (l < vsw) ? POL : ~POL;
        d = (a >= 0) && (a < vact) && (p >= 0) && (p < w);
        e = '0;
        if (d) begin
          e.de  = 1'b1;
          e.sof = (a == 0) && (p == 0);
          e.eol = (p == w - 1);
          e.x   = p[PW-1:0];
          e.y   = a[VW-1:0];
        end
        step(h, v, d, e);
        n++;
      end
    end
  endtask

  // Reduced timing: 8/4/16/4 by 2/2/6/2.
  task automatic red_frame(input int bad_line);
    gen_frame(8, 4, 16, 4, 2, 2, 6, 2, bad_line, -1);
  endtask

  // 640-wide line timing; vertical compressed to keep the run short.
  task automatic vga_frame(input int hfp);
    gen_frame(96, 48, 640, hfp, 1, 1, 3, 1, -1, -1);
  endtask

  task automatic chk_meas(input string tag, input int ht, input int ha, input int vt, input int va);
    logic [PW-1:0] eht, eha;
    logic [VW-1:0] evt, eva;
    eht = ht[PW-1:0];
    eha = ha[PW-1:0];
    evt = vt[VW-1:0];
    eva = va[VW-1:0];
    chk_eq(tag, {out_h_total, out_h_active, out_v_total, out_v_active}, {eht, eha, evt, eva});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    hs = ~POL;
    vs = ~POL;
    de = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    idle(4);
  endtask

  initial begin
    int e0;
    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_pix", {out_de, out_sof, out_eol, out_x, out_y}, '0);
    chk_eq("rst_meas", {out_h_total, out_h_active, out_v_total, out_v_active,
                        out_locked, out_err}, '0);
    rst = 1'b0;
    idle(4);

    // Reduced stream: coordinates, publish after 2nd VS, lock at 5th VS
    e0 = err_cnt;
    red_frame(-1);
    chk_meas("red_no_pub_f0", 0, 0, 0, 0);
    red_frame(-1);
    chk_meas("red_meas_f1", 32, 16, 12, 6);
    red_frame(-1);
    red_frame(-1);
    chk_eq("red_lock_f3", out_locked, 1'b0);
    red_frame(-1);
    chk_eq("red_lock_f4", out_locked, 1'b1);
    chk_eq("red_err_clean", err_cnt - e0, 0);

    // Short DE on line 3, then recovery
    red_frame(3);
    chk_eq("bad_err_line", err_cnt - e0, 1);
    chk_eq("bad_lock_hold", out_locked, 1'b1);
    red_frame(-1);
    chk_eq("bad_lock_drop", out_locked, 1'b0);
    chk_eq("bad_err_frame", err_cnt - e0, 2);
    chk_meas("bad_meas", 32, 16, 12, 6);
    red_frame(-1);
    red_frame(-1);
    chk_eq("relock_f8", out_locked, 1'b0);
    red_frame(-1);
    chk_eq("relock_f9", out_locked, 1'b1);
    chk_eq("relock_err", err_cnt - e0, 2);

    // Asynchronous reset in the middle of active line 2
    e0 = err_cnt;
    gen_frame(8, 4, 16, 4, 2, 2, 6, 2, -1, 6 * 32 + 20);
    chk_eq("pre_rst_de", out_de, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_eq("async_rst_pix", {out_de, out_sof, out_eol, out_x, out_y}, '0);
    chk_eq("async_rst_meas", {out_h_total, out_h_active, out_v_total, out_v_active,
                              out_locked, out_err}, '0);
    hs = ~POL;
    vs = ~POL;
    de = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    idle(4);
    red_frame(-1);
    chk_meas("post_rst_f0", 0, 0, 0, 0);
    red_frame(-1);
    chk_meas("post_rst_f1", 32, 16, 12, 6);
    chk_eq("post_rst_err", err_cnt - e0, 0);

    // 640-wide lines, then switch from 800 to 858 cycles per line
    pulse_reset();
    e0 = err_cnt;
    vga_frame(16);
    vga_frame(16);
    chk_meas("vga_meas", 800, 640, 6, 3);
    vga_frame(16);
    vga_frame(16);
    chk_eq("vga_lock_f3", out_locked, 1'b0);
    vga_frame(16);
    chk_eq("vga_lock_f4", out_locked, 1'b1);
    chk_eq("vga_err_clean", err_cnt - e0, 0);
    vga_frame(74);
    vga_frame(74);
    chk_meas("vga858_meas", 858, 640, 6, 3);
    chk_eq("vga858_lock", out_locked, 1'b0);
    chk_eq("vga858_err", err_cnt - e0, 1);

    // HS static past counter range: one error, saturated period, empty frame
    pulse_reset();
    e0 = err_cnt;
    step(POL, POL, 1'b0, '0);
    idle(17000);
    chk_eq("sat_err", err_cnt - e0, 1);
    step(POL, POL, 1'b0, '0);
    idle(3);
    chk_meas("sat_meas", 16383, 0, 1, 0);
    chk_eq("sat_err_after", err_cnt - e0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/display_hdmi_vga_timing_det.md
Name: display_hdmi_vga_timing_det

Overview:
- Receive-side counterpart of the display sync generator: takes a raw HS/VS/DE video timing stream and recovers per-pixel active coordinates.
- Measures line and frame geometry and reports lock once the timing is stable.
- Sits after the capture or loopback path, ahead of scalers and overlay logic, and serves as a checker on the generator's output.

Parameters:
- PW, 14, width of horizontal counters and out_x / out_h_* outputs.
- VW, 12, width of vertical counters and out_y / out_v_* outputs.
- LOCK_FRAMES, 3, consecutive identical frames required to assert out_locked (1..7).
- SYNC_POL, 0, active level of in_hs and in_vs during the sync pulse (0 = active-low).

Ports:
- in_pclk  input  1  pixel clock; all logic on rising edge.
- in_rst  input  1  asynchronous active-high reset.
- in_hs  input  1  horizontal sync.
- in_vs  input  1  vertical sync.
- in_de  input  1  data enable.
- out_x  output  PW  active pixel index within the line.
- out_y  output  VW  active line index within the frame.
- out_de  output  1  delayed in_de, aligned with out_x/out_y.
- out_sof  output  1  one-cycle pulse on the first active pixel of a frame.
- out_eol  output  1  one-cycle pulse on the last active pixel of a line.
- out_h_total  output  PW  measured pclk cycles per line.
- out_h_active  output  PW  measured DE-high cycles per line.
- out_v_total  output  VW  measured lines per frame.
- out_v_active  output  VW  measured active lines per frame.
- out_locked  output  1  timing stable.
- out_err  output  1  one-cycle pulse on a measurement fault.

Behaviour:
- Reset values: all outputs 0; FSM in SEARCH.
- Input stage: in_hs, in_vs, in_de are registered once; edges are detected against a second register.
- Sync start is the transition into the SYNC_POL level. HS start marks a line start; VS start marks a frame start.
- Coordinate path latency is fixed at 2 cycles: an input sampled at edge n appears on out_de/out_x/out_y at edge n+2.
- out_x: 0 on the first DE-high cycle of a line, +1 per DE-high cycle; holds 0 while DE is low.
- out_y: 0 for the first DE line after frame start, +1 on each DE falling edge; cleared at frame start.
- out_x and out_y are 0 whenever out_de = 0.
- out_sof = out_de & first pixel of the first active line. out_eol = out_de & next-cycle in_de low. out_eol needs the lookahead; the 2-cycle latency covers it.
- h counter: cycles since the last HS start, saturating at 2^PW-1.
  - At HS start, the measured line period is latched, equal to the cycle distance between consecutive HS starts.
  - The counter then restarts.
  - If the counter saturates, out_err pulses once per line.
- DE width counter: latched at each DE falling edge.
  - The first DE line of a frame sets the frame reference.
  - Any later line in the same frame with a different width marks the frame inconsistent and pulses out_err.
- Line counter: HS starts per frame. Active line counter: DE falling edges per frame. Both are latched at VS start.
- out_h_total, out_h_active, out_v_total, out_v_active:
  - Update only at VS start, and only after at least one complete frame has been measured.
  - Otherwise they hold.
- FSM states:
  - SEARCH: wait for the first VS start, then go to MEASURE. No values are published.
  - MEASURE: at the next VS start, publish measurements, set match count to 0, go to TRACK.
  - TRACK: at each VS start, compare the new h_total/h_active/v_total/v_active with the published values.
    - All equal and frame consistent: match count +1, saturating at LOCK_FRAMES.
    - Otherwise: match count 0, out_locked 0, out_err pulses, new values are published.
    - out_locked = (match count == LOCK_FRAMES).
- Simultaneous HS start and VS start on one cycle (normal for the generator): the line is counted in the ending frame before the frame counters clear.
- A DE falling edge on the same cycle as VS start counts toward the ending frame.
- A frame with zero DE lines publishes h_active = 0 and v_active = 0.
- Reset mid-frame: asynchronous clear of all state; detection restarts from SEARCH.

Test Plan:
- 640x480@60 stream (sync 96/48/640/16, 2/33/480/10, active-low) -> after the 2nd VS start: h_total 800, h_active 640, v_total 525, v_active 480. out_locked rises at the 5th VS start (MEASURE + 3 matches). out_err never pulses.
- Reduced timing (8/4/16/4, 2/2/6/2) -> out_x runs 0..15 with out_eol at x = 15. out_y runs 0..5. out_sof is asserted exactly once per frame, on x = 0 / y = 0. 2-cycle latency from in_de rise to out_de rise.
- Locked reduced stream, then one frame with line 3 DE width 15 -> out_err pulse at line 3's DE falling edge; out_locked drops at the next VS start; re-locks 3 frames after clean timing resumes.
- Switch from 800-cycle to 858-cycle lines mid-run -> out_h_total becomes 858 at the next VS start, out_locked 0, out_err one pulse.
- in_rst asserted mid-line during active video -> all outputs 0 immediately (asynchronous). After release, no measurement update before the 2nd VS start.
- HS held static beyond 2^PW cycles -> out_err pulses once, h counter saturates at 16383, no wrap.
